arb_ctrl_cond: RTL and testbench

- Control end of the conditional mux/demux datapath: generates the one-hot `arb_pop` / `arb_push` vectors that move words from 4 input FIFOs to 4 output FIFOs.
- Selects an input FIFO by round-robin among non-empty inputs.
- Routes the word to the output FIFO named by the destination field in the input head word.
- Stalls on back-pressure (output almost-full); tracks activity with a small FSM.

---
 rtl/arb_ctrl_cond_pkg.sv | 33 +++
 rtl/arb_ctrl_cond_rr_pick4.sv | 39 +++
 rtl/arb_ctrl_cond.sv | 133 +++++++++++++
 tb/tb_arb_ctrl_cond.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_ctrl_cond_pkg.sv
// Shared types and constants for the conditional mux/demux arbiter.
// ARB_CNT_EN adds the constants used by the optional per-output push counters.
package arb_ctrl_cond_pkg;

    localparam int FIFO_UNITS = 4;
    localparam int WORD_SIZE  = 10;
    localparam int IDX_W      = 2;

    // Destination index lives in the top two bits of each data word.
    localparam int DEST_MSB   = WORD_SIZE - 1;
    localparam int DEST_LSB   = WORD_SIZE - 2;
    localparam int DEST_W     = DEST_MSB - DEST_LSB + 1;

`ifdef ARB_CNT_EN
    localparam int PTR_L      = 3;
    localparam int CNT_W      = PTR_L + 2;
`endif

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_PAUSE  = 2'd3
    } arb_state_e;

    function automatic logic [IDX_W-1:0] dest_of(
        input logic [DEST_W*FIFO_UNITS-1:0] dest,
        input logic [IDX_W-1:0]             idx
    );
        return dest[idx*DEST_W +: DEST_W];
    endfunction

endpackage

// File: rtl/arb_ctrl_cond_rr_pick4.sv
// Combinational 4-way round-robin picker: first request at or above ptr, wrapping.
module arb_ctrl_cond_rr_pick4
    import arb_ctrl_cond_pkg::*;
(
    input  logic [FIFO_UNITS-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic [FIFO_UNITS-1:0] gnt,
    output logic [IDX_W-1:0]      gnt_idx,
    output logic                  gnt_vld
);

    logic [FIFO_UNITS-1:0] req_rot;
    logic [IDX_W-1:0]      off;

    // Rotate so the pointer position lands on bit 0; the lowest set bit then wins.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_UNITS; gi++) begin : g_rot
            assign req_rot[gi] = req[ptr + IDX_W'(gi)];
        end
    endgenerate

    always_comb begin
        off     = '0;
        gnt_vld = 1'b0;
        for (int k = FIFO_UNITS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                off     = IDX_W'(k);
                gnt_vld = 1'b1;
            end
        end
        gnt_idx = ptr + off;
        gnt     = '0;
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/arb_ctrl_cond.sv
// Arbiter control: round-robin pop from 4 input FIFOs, push to the destination output FIFO.
// Define ARB_CNT_EN to add saturating per-output push counters push_cnt0..push_cnt3.
module arb_ctrl_cond
    import arb_ctrl_cond_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_L,
    input  logic [FIFO_UNITS-1:0]        fifo_empty,
    input  logic [DEST_W*FIFO_UNITS-1:0] fifo_dest,
    input  logic [FIFO_UNITS-1:0]        out_almost_full,
    output logic [FIFO_UNITS-1:0]        arb_pop,
    output logic [FIFO_UNITS-1:0]        arb_push,
    output logic                         arb_idle,
    output logic                         arb_pause
`ifdef ARB_CNT_EN
    ,
    output logic [CNT_W-1:0]             push_cnt0,
    output logic [CNT_W-1:0]             push_cnt1,
    output logic [CNT_W-1:0]             push_cnt2,
    output logic [CNT_W-1:0]             push_cnt3
`endif
);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  arb_idle_q, arb_idle_d;
    logic                  arb_pause_q, arb_pause_d;

    logic [FIFO_UNITS-1:0] req;
    logic [FIFO_UNITS-1:0] pick_gnt;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_vld;
    logic                  grant;
    logic                  any_af;
    logic                  all_empty;

    // An input is a candidate only if its head word's destination can accept it.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_UNITS; gi++) begin : g_req
            assign req[gi] = ~fifo_empty[gi] & ~out_almost_full[dest_of(fifo_dest, IDX_W'(gi))];
        end
    endgenerate

    arb_ctrl_cond_rr_pick4 u_pick (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    assign any_af    = |out_almost_full;
    assign all_empty = &fifo_empty;
    assign grant     = (state_q == ST_ACTIVE) && pick_vld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE: begin
                if (any_af)          state_d = ST_PAUSE;
                else if (!all_empty) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_af)          state_d = ST_PAUSE;
                else if (all_empty)  state_d = ST_IDLE;
            end
            ST_PAUSE: begin
                if (!any_af)         state_d = ST_IDLE;
            end
            default:   state_d = ST_INIT;
        endcase

        rr_ptr_d    = grant ? (pick_idx + IDX_W'(1)) : rr_ptr_q;
        arb_idle_d  = (state_d == ST_IDLE);
        arb_pause_d = (state_d == ST_PAUSE);
    end

    // Pop and push come from the same grant, so a word is never popped without its push.
    always_comb begin
        arb_pop  = '0;
        arb_push = '0;
        if (grant) begin
            arb_pop                            = pick_gnt;
            arb_push[dest_of(fifo_dest, pick_idx)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_INIT;
            rr_ptr_q    <= '0;
            arb_idle_q  <= 1'b0;
            arb_pause_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            arb_idle_q  <= arb_idle_d;
            arb_pause_q <= arb_pause_d;
        end
    end

    assign arb_idle  = arb_idle_q;
    assign arb_pause = arb_pause_q;

`ifdef ARB_CNT_EN
    logic [FIFO_UNITS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < FIFO_UNITS; i++) begin
            if (arb_push[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign push_cnt0 = cnt_q[0];
    assign push_cnt1 = cnt_q[1];
    assign push_cnt2 = cnt_q[2];
    assign push_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_arb_ctrl_cond.sv
// Bench for arb_ctrl_cond: directed vector table, async-reset sequence, random run vs a model.
module tb_arb_ctrl_cond;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [3:0] fifo_empty;
    logic [7:0] fifo_dest;
    logic [3:0] out_almost_full;
    logic [3:0] arb_pop;
    logic [3:0] arb_push;
    logic       arb_idle;
    logic       arb_pause;
`ifdef ARB_CNT_EN
    logic [4:0] push_cnt0, push_cnt1, push_cnt2, push_cnt3;
    localparam int CNT_MAX = (1 << (3 + 2)) - 1;
`endif

    arb_ctrl_cond dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .fifo_empty      (fifo_empty),
        .fifo_dest       (fifo_dest),
        .out_almost_full (out_almost_full),
        .arb_pop         (arb_pop),
        .arb_push        (arb_push),
        .arb_idle        (arb_idle),
        .arb_pause       (arb_pause)
`ifdef ARB_CNT_EN
        ,
        .push_cnt0       (push_cnt0),
        .push_cnt1       (push_cnt1),
        .push_cnt2       (push_cnt2),
        .push_cnt3       (push_cnt3)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: named activity modes, pointer as an integer, counters as ints.
    typedef enum {M_INIT, M_IDLE, M_RUN, M_HOLD} mode_t;
    mode_t      m_mode;
    int         m_ptr;
    int         m_cnt[4];
    logic [3:0] cur_e;
    logic [7:0] cur_d;
    logic [3:0] cur_af;

    typedef struct {
        logic [3:0] e;
        logic [7:0] d;
        logic [3:0] af;
        logic [3:0] pop;
        logic [3:0] push;
        logic       idle;
        logic       pause;
    } vec_t;
    vec_t tbl[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int dest_idx(input logic [7:0] d, input int i);
        logic [7:0] t;
        t = d >> (2 * i);
        return int'(t[1:0]);
    endfunction

    task automatic model_eval(output logic [3:0] pop, output logic [3:0] push, output int win);
        pop  = '0;
        push = '0;
        win  = -1;
        if (m_mode == M_RUN) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (win < 0 && !cur_e[i] && !cur_af[dest_idx(cur_d, i)]) win = i;
            end
        end
        if (win >= 0) begin
            pop[win] = 1'b1;
            push[dest_idx(cur_d, win)] = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_mode = M_INIT;
        m_ptr  = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        logic [3:0] p, q;
        int w;
        logic busy_out, all_empty;
        model_eval(p, q, w);
        if (w >= 0) m_ptr = (w + 1) % 4;
        for (int i = 0; i < 4; i++)
            if (q[i] && m_cnt[i] < (1 << 5) - 1) m_cnt[i]++;
        busy_out  = (cur_af != 4'b0000);
        all_empty = (cur_e == 4'b1111);
        case (m_mode)
            M_INIT: m_mode = M_IDLE;
            M_IDLE: m_mode = busy_out ? M_HOLD : (all_empty ? M_IDLE : M_RUN);
            M_RUN:  m_mode = busy_out ? M_HOLD : (all_empty ? M_IDLE : M_RUN);
            M_HOLD: m_mode = busy_out ? M_HOLD : M_IDLE;
            default: m_mode = M_INIT;
        endcase
    endtask

    // One transaction: clock edge (model follows), drive new inputs, settle to the negedge.
    task automatic drive_step(input logic [3:0] e, input logic [7:0] d, input logic [3:0] af);
        @(posedge clk);
        model_step();
        #1;
        fifo_empty      = e;
        fifo_dest       = d;
        out_almost_full = af;
        cur_e  = e;
        cur_d  = d;
        cur_af = af;
        @(negedge clk);
    endtask

    task automatic show(input string tag);
        $display("[%0t] %s empty=%b dest=%h af=%b pop=%b push=%b idle=%b pause=%b",
                 $time, tag, fifo_empty, fifo_dest, out_almost_full, arb_pop, arb_push, arb_idle, arb_pause);
    endtask

    task automatic check_model(input string name);
        logic [3:0] p, q;
        int w;
        model_eval(p, q, w);
        check(name, {22'd0, arb_pop, arb_push, arb_idle, arb_pause},
                    {22'd0, p, q, (m_mode == M_IDLE), (m_mode == M_HOLD)});
`ifdef ARB_CNT_EN
        check({name, "_cnt"}, {12'd0, push_cnt3, push_cnt2, push_cnt1, push_cnt0},
              {12'd0, 5'(m_cnt[3]), 5'(m_cnt[2]), 5'(m_cnt[1]), 5'(m_cnt[0])});
`endif
    endtask

    initial begin
        //           empty    dest   af       pop      push     idle  pause
        tbl[0]  = '{4'b1011, 8'h10, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[1]  = '{4'b1011, 8'h10, 4'b0000, 4'b0100, 4'b0010, 1'b0, 1'b0};
        tbl[2]  = '{4'b1111, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{4'b1111, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[4]  = '{4'b0000, 8'hE4, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[5]  = '{4'b0000, 8'hE4, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b0};
        tbl[6]  = '{4'b0000, 8'hE4, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0};
        tbl[7]  = '{4'b0000, 8'hE4, 4'b0000, 4'b0010, 4'b0010, 1'b0, 1'b0};
        tbl[8]  = '{4'b0000, 8'hE4, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0};
        tbl[9]  = '{4'b0000, 8'hE4, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b0};
        tbl[10] = '{4'b0000, 8'hE4, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0};
        tbl[11] = '{4'b0000, 8'hE4, 4'b0000, 4'b0010, 4'b0010, 1'b0, 1'b0};
        tbl[12] = '{4'b0000, 8'hE4, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0};
        tbl[13] = '{4'b1100, 8'h0F, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[14] = '{4'b1100, 8'h0F, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tbl[15] = '{4'b1100, 8'h0F, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tbl[16] = '{4'b1100, 8'h0F, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[17] = '{4'b1100, 8'h0F, 4'b0000, 4'b0001, 4'b1000, 1'b0, 1'b0};
        tbl[18] = '{4'b1100, 8'h0F, 4'b0000, 4'b0010, 4'b1000, 1'b0, 1'b0};
        tbl[19] = '{4'b0110, 8'h02, 4'b0100, 4'b1000, 4'b0001, 1'b0, 1'b0};
        tbl[20] = '{4'b1111, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tbl[21] = '{4'b1111, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};

        reset_L         = 1'b0;
        fifo_empty      = 4'b1111;
        fifo_dest       = 8'h00;
        out_almost_full = 4'b0000;
        cur_e  = 4'b1111;
        cur_d  = 8'h00;
        cur_af = 4'b0000;
        model_reset();

        repeat (3) @(negedge clk);
        show("reset");
        check("reset_outputs", {26'd0, arb_pop, arb_push, arb_idle, arb_pause}, 32'd0);
        reset_L = 1'b1;
        #1;
        check("init_outputs", {26'd0, arb_pop, arb_push, arb_idle, arb_pause}, 32'd0);

        for (int v = 0; v < 22; v++) begin
            drive_step(tbl[v].e, tbl[v].d, tbl[v].af);
            show($sformatf("vec%0d", v));
            check($sformatf("vec%0d", v), {22'd0, arb_pop, arb_push, arb_idle, arb_pause},
                  {22'd0, tbl[v].pop, tbl[v].push, tbl[v].idle, tbl[v].pause});
        end

        // Async reset asserted between edges while granting.
        drive_step(4'b0000, 8'hE4, 4'b0000);
        show("pre_rst0");
        check_model("pre_rst0");
        drive_step(4'b0000, 8'hE4, 4'b0000);
        show("pre_rst1");
        check_model("pre_rst1");
        #2;
        reset_L = 1'b0;
        #1;
        show("async_rst");
        check("async_rst_out", {26'd0, arb_pop, arb_push, arb_idle, arb_pause}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        #1;
        show("rst_release");
        check("rst_release_init", {26'd0, arb_pop, arb_push, arb_idle, arb_pause}, 32'd0);
        drive_step(4'b0000, 8'hE4, 4'b0000);
        show("post_rst_idle");
        check_model("post_rst_idle");
        check("post_rst_idle_flag", {31'd0, arb_idle}, 32'd1);
        drive_step(4'b0000, 8'hE4, 4'b0000);
        show("post_rst_grant");
        check_model("post_rst_grant");
        check("ptr_reset", {28'd0, arb_pop}, 32'b0001);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] e, af;
            logic [7:0] d;
            e  = 4'($urandom);
            d  = 8'($urandom);
            af = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            drive_step(e, d, af);
            show($sformatf("rnd%0d", n));
            check_model($sformatf("rnd%0d", n));
        end

`ifdef ARB_CNT_EN
        // Saturation: a long run of pushes to output 0 only.
        reset_L = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset_L = 1'b1;
        for (int n = 0; n < 45; n++) begin
            drive_step(4'b1110, 8'h00, 4'b0000);
            show($sformatf("sat%0d", n));
        end
        check("cnt0_saturated", {27'd0, push_cnt0}, 32'(CNT_MAX));
        check("cnt_others_zero", {17'd0, push_cnt3, push_cnt2, push_cnt1}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
